// File: rtl/printer_spool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : printer_pkg
// Description : Shared constants for the Z80 printer spool: status bit
//               positions, the idle "ready" status byte, port decode base
//               and the notify state encodings.
// Revision    : 1.0  initial release
// ============================================================================
package printer_pkg;

  // Centronics-style status bit positions as seen by the Z80
  localparam int         c_stat_busy      = 7;
  localparam int         c_stat_paper_out = 6;
  localparam int         c_stat_select    = 5;
  localparam int         c_stat_nfault    = 4;

  // Status byte when the spool can accept data (SELECT | NFAULT)
  localparam logic [7:0] c_status_ready   = 8'h30;

  // TRS_A[8:2] value selecting ports 0xF8-0xFB (bit 8 clear = valid address)
  localparam logic [6:0] c_port_base      = 7'h3E;

  // Notify state machine encodings
  typedef logic [1:0] state_t;
  localparam state_t c_st_idle   = 2'd0;
  localparam state_t c_st_armed  = 2'd1;
  localparam state_t c_st_notify = 2'd2;

  // Builds the status byte; only BUSY depends on the spool state
  function automatic logic [7:0] status_byte(input logic full);
    logic [7:0] s;
    s                   = 8'h00;
    s[c_stat_select]    = 1'b1;
    s[c_stat_nfault]    = 1'b1;
    s[c_stat_paper_out] = 1'b0;
    s[c_stat_busy]      = full;
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/printer_spool_if.sv
`default_nettype none
// ============================================================================
// Module      : printer_spool_if
// Description : Bundles the Z80 I/O side and the ESP drain side of the
//               printer spool. master = bus/ESP side, slave = the spool.
// Revision    : 1.0  initial release
// ============================================================================
interface printer_spool_if #(
  parameter int DEPTH_LOG2 = 6
);
  // Z80 side
  logic                io_access;
  logic [8:0]          TRS_A;
  logic [7:0]          TRS_D;
  logic                TRS_IN;
  logic                TRS_OUT;
  logic [7:0]          status_dout;
  // ESP side
  logic                pop_req;
  logic [7:0]          pop_data;
  logic                pop_valid;
  logic                notify;
  logic                overflow;
  logic                ovf_clr;
  logic [DEPTH_LOG2:0] level;

  modport master (
    output io_access, TRS_A, TRS_D, TRS_IN, TRS_OUT, pop_req, ovf_clr,
    input  status_dout, pop_data, pop_valid, notify, overflow, level
  );

  modport slave (
    input  io_access, TRS_A, TRS_D, TRS_IN, TRS_OUT, pop_req, ovf_clr,
    output status_dout, pop_data, pop_valid, notify, overflow, level
  );
endinterface
`default_nettype wire

// File: rtl/printer_spool_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spool_fifo
// Description : Synchronous byte FIFO with registered read. A pop on an empty
//               FIFO returns 0; a push while full is accepted only when a pop
//               frees a slot in the same cycle.
// Revision    : 1.0  initial release
// ============================================================================
module spool_fifo #(
  parameter int DEPTH_LOG2 = 6
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  push,
  input  wire logic [7:0]            din,
  input  wire logic                  pop,
  output logic      [7:0]            dout,
  output logic                       full,
  output logic                       empty,
  output logic      [DEPTH_LOG2:0]   level
);
  localparam int                    c_depth   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   c_full    = (DEPTH_LOG2+1)'(c_depth);
  localparam logic [DEPTH_LOG2-1:0] c_ptr_one = (DEPTH_LOG2)'(1);

  logic [7:0]            mem [c_depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [7:0]            dout_q, dout_d;
  logic                  push_ok, pop_ok;

  assign full    = (level_q == c_full);
  assign empty   = (level_q == '0);
  // Full implies non-empty, so a simultaneous pop always makes room
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  // Next-state for pointers, occupancy and the read register
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    level_d  = level_q + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + c_ptr_one;
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + c_ptr_one;
      dout_d   = mem[rd_ptr_q];
    end else if (pop) begin
      dout_d   = 8'h00;
    end
  end

  // Storage array: no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  // Control and read-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      dout_q   <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      dout_q   <= dout_d;
    end
  end

  assign dout  = dout_q;
  assign level = level_q;
endmodule
`default_nettype wire

// File: rtl/printer_spool.sv
`default_nettype none
// ============================================================================
// Module      : printer_spool
// Description : Buffers Z80 OUTs to printer ports 0xF8-0xFB, answers status
//               reads locally and requests the ESP to drain via notify.
// Revision    : 1.0  initial release
// ============================================================================
module printer_spool
  import printer_pkg::*;
#(
  parameter int DEPTH_LOG2   = 6,
  parameter int NOTIFY_LEVEL = 32,
  parameter int FLUSH_CYCLES = 840000
) (
  input  wire logic        clk,
  input  wire logic        RST_N,
  printer_spool_if.slave   bus
);
  localparam logic [DEPTH_LOG2:0] c_full         = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] c_notify_level = (DEPTH_LOG2+1)'(NOTIFY_LEVEL);
  localparam logic [19:0]         c_flush_last   = 20'(FLUSH_CYCLES - 1);

  logic [7:0]          fifo_dout;
  logic                fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0] fifo_level, level_nxt;
  logic                sel, push, push_ok, pop_ok, drop;

  logic [7:0]  status_q, status_d;
  logic        overflow_q, overflow_d;
  logic        pop_valid_q, pop_valid_d;
  state_t      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;

  // The Z80 IN strobe and the low address bits do not affect the spool
  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.TRS_IN, bus.TRS_A[1:0]};

  assign sel     = (bus.TRS_A[8:2] == c_port_base);
  assign push    = bus.io_access & sel & ~bus.TRS_OUT;
  assign push_ok = push & (~fifo_full | bus.pop_req);
  assign pop_ok  = bus.pop_req & ~fifo_empty;
  assign drop    = push & ~push_ok;

  spool_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk   (clk),
    .rst_n (RST_N),
    .push  (push),
    .din   (bus.TRS_D),
    .pop   (bus.pop_req),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Status, overflow and pop-valid track the post-update occupancy
  always_comb begin
    level_nxt   = fifo_level + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(pop_ok);
    status_d    = status_byte(level_nxt == c_full);
    overflow_d  = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : overflow_q);
    pop_valid_d = bus.pop_req ? ~fifo_empty : pop_valid_q;
  end

  // Notify FSM: arm on first byte, notify on threshold or idle timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      c_st_idle: begin
        if (level_nxt != '0) state_d = c_st_armed;
      end
      c_st_armed: begin
        if (level_nxt == '0)                 state_d = c_st_idle;
        else if (level_nxt >= c_notify_level) state_d = c_st_notify;
        else if (push)                        cnt_d   = '0;
        else if (cnt_q == c_flush_last)       state_d = c_st_notify;
        else                                  cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 20'd1;
      end
      c_st_notify: begin
        if (level_nxt == '0) state_d = c_st_idle;
      end
      default: state_d = c_st_idle;
    endcase
  end

  // Control registers, all cleared asynchronously
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      status_q    <= c_status_ready;
      overflow_q  <= 1'b0;
      pop_valid_q <= 1'b0;
      state_q     <= c_st_idle;
      cnt_q       <= '0;
    end else begin
      status_q    <= status_d;
      overflow_q  <= overflow_d;
      pop_valid_q <= pop_valid_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.status_dout = status_q;
  assign bus.pop_data    = fifo_dout;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.notify      = (state_q == c_st_notify);
  assign bus.overflow    = overflow_q;
  assign bus.level       = fifo_level;
endmodule
`default_nettype wire

// File: tb/tb_printer_spool.sv
`default_nettype none
// ============================================================================
// Module      : tb_printer_spool
// Description : Directed self-checking bench for printer_spool. The idle
//               flush timeout is shortened to keep the run brief.
// Revision    : 1.0  initial release
// ============================================================================
module tb_printer_spool;
  localparam int FLUSH = 100;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  printer_spool_if #(.DEPTH_LOG2(6)) bus ();

  printer_spool #(.DEPTH_LOG2(6), .NOTIFY_LEVEL(32), .FLUSH_CYCLES(FLUSH)) dut (
    .clk   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // {status, level, notify, overflow, pop_valid, pop_data}
  function automatic logic [25:0] snap();
    return {bus.status_dout, bus.level, bus.notify, bus.overflow, bus.pop_valid, bus.pop_data};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] addr, input logic [7:0] data);
    bus.io_access = 1'b1; bus.TRS_A = addr; bus.TRS_D = data;
    bus.TRS_OUT = 1'b0;   bus.TRS_IN = 1'b1;
    tick();
    bus.io_access = 1'b0; bus.TRS_OUT = 1'b1;
  endtask

  task automatic rd(input logic [8:0] addr);
    bus.io_access = 1'b1; bus.TRS_A = addr; bus.TRS_IN = 1'b0; bus.TRS_OUT = 1'b1;
    tick();
    bus.io_access = 1'b0; bus.TRS_IN = 1'b1;
  endtask

  task automatic pop(output logic [7:0] d, output logic v);
    bus.pop_req = 1'b1;
    tick();
    bus.pop_req = 1'b0;
    d = bus.pop_data; v = bus.pop_valid;
  endtask

  task automatic push_pop(input logic [7:0] data, output logic [7:0] d, output logic v);
    bus.pop_req = 1'b1;
    wr(9'h0F8, data);
    bus.pop_req = 1'b0;
    d = bus.pop_data; v = bus.pop_valid;
  endtask

  task automatic test_reset();
    bus.io_access = 1'b0; bus.TRS_A = 9'h100; bus.TRS_D = 8'h00;
    bus.TRS_IN = 1'b1; bus.TRS_OUT = 1'b1; bus.pop_req = 1'b0; bus.ovf_clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (snap() !== {8'h30, 7'd0, 3'b000, 8'h00}) begin
      errors++; $display("FAIL reset_state: got %h want %h", snap(), {8'h30, 7'd0, 3'b000, 8'h00});
    end
    rst_n = 1'b1;
    tick();
    rd(9'h0F8);
    checks++;
    if (snap() !== {8'h30, 7'd0, 3'b000, 8'h00}) begin
      errors++; $display("FAIL status_read: got %h want %h", snap(), {8'h30, 7'd0, 3'b000, 8'h00});
    end
  endtask

  task automatic test_decode();
    logic [7:0] d; logic v;
    wr(9'h1F9, 8'h11);   // bit 8 set: invalid address
    wr(9'h0FC, 8'h22);
    wr(9'h0F7, 8'h33);
    rd(9'h0FB);
    checks++;
    if (bus.level !== 7'd0) begin
      errors++; $display("FAIL decode_reject: level got %0d want 0", bus.level);
    end
    wr(9'h0FB, 8'h44);
    checks++;
    if (bus.level !== 7'd1) begin
      errors++; $display("FAIL decode_accept: level got %0d want 1", bus.level);
    end
    pop(d, v);
    checks++;
    if ({v, d} !== {1'b1, 8'h44}) begin
      errors++; $display("FAIL decode_pop: got %h want %h", {v, d}, {1'b1, 8'h44});
    end
  endtask

  task automatic test_abc();
    logic [7:0] d; logic v;
    logic [7:0] exp_b [3] = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++) wr(9'h0F9, exp_b[i]);
    checks++;
    if ({bus.level, bus.notify} !== {7'd3, 1'b0}) begin
      errors++; $display("FAIL abc_level: got %h want %h", {bus.level, bus.notify}, {7'd3, 1'b0});
    end
    for (int i = 0; i < 3; i++) begin
      pop(d, v);
      checks++;
      if ({v, d} !== {1'b1, exp_b[i]}) begin
        errors++; $display("FAIL abc_pop[%0d]: got %h want %h", i, {v, d}, {1'b1, exp_b[i]});
      end
    end
    pop(d, v);
    checks++;
    if ({v, d} !== 9'h000) begin
      errors++; $display("FAIL abc_empty_pop: got %h want 000", {v, d});
    end
  endtask

  task automatic test_fill_overflow();
    logic [7:0] d; logic v;
    for (int i = 0; i < 64; i++) begin
      wr(9'h0F8 + 9'(i % 4), 8'(i));
      if (i == 30) begin
        checks++;
        if ({bus.level, bus.notify} !== {7'd31, 1'b0}) begin
          errors++; $display("FAIL notify_31: got %h want %h", {bus.level, bus.notify}, {7'd31, 1'b0});
        end
      end
      if (i == 31) begin
        checks++;
        if ({bus.level, bus.notify} !== {7'd32, 1'b1}) begin
          errors++; $display("FAIL notify_32: got %h want %h", {bus.level, bus.notify}, {7'd32, 1'b1});
        end
      end
    end
    checks++;
    if (snap() !== {8'hB0, 7'd64, 3'b100, 8'h00}) begin
      errors++; $display("FAIL full_state: got %h want %h", snap(), {8'hB0, 7'd64, 3'b100, 8'h00});
    end
    wr(9'h0FA, 8'hAA);
    checks++;
    if (snap() !== {8'hB0, 7'd64, 3'b110, 8'h00}) begin
      errors++; $display("FAIL overflow_set: got %h want %h", snap(), {8'hB0, 7'd64, 3'b110, 8'h00});
    end
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_clr: got %b want 0", bus.overflow);
    end
    bus.ovf_clr = 1'b1; wr(9'h0F8, 8'hBB); bus.ovf_clr = 1'b0;
    checks++;
    if ({bus.level, bus.overflow} !== {7'd64, 1'b1}) begin
      errors++; $display("FAIL overflow_clr_vs_drop: got %h want %h", {bus.level, bus.overflow}, {7'd64, 1'b1});
    end
    bus.ovf_clr = 1'b1; tick(); bus.ovf_clr = 1'b0;
    for (int i = 0; i < 64; i++) begin
      pop(d, v);
      checks++;
      if ({v, d} !== {1'b1, 8'(i)}) begin
        errors++; $display("FAIL fill_pop[%0d]: got %h want %h", i, {v, d}, {1'b1, 8'(i)});
      end
    end
    checks++;
    if (snap() !== {8'h30, 7'd0, 3'b001, 8'h3F}) begin
      errors++; $display("FAIL drained_state: got %h want %h", snap(), {8'h30, 7'd0, 3'b001, 8'h3F});
    end
    pop(d, v);
    checks++;
    if ({v, d} !== 9'h000) begin
      errors++; $display("FAIL dropped_not_stored: got %h want 000", {v, d});
    end
  endtask

  task automatic test_flush();
    logic [7:0] d; logic v;
    int n;
    for (int i = 0; i < 4; i++) wr(9'h0F8, 8'h10 + 8'(i));
    repeat (50) tick();
    checks++;
    if ({bus.level, bus.notify} !== {7'd4, 1'b0}) begin
      errors++; $display("FAIL flush_early: got %h want %h", {bus.level, bus.notify}, {7'd4, 1'b0});
    end
    wr(9'h0F8, 8'h14);
    n = 0;
    while (!bus.notify && n < FLUSH + 20) begin
      tick();
      n++;
    end
    checks++;
    if (n !== FLUSH) begin
      errors++; $display("FAIL flush_timing: notify after %0d cycles want %0d", n, FLUSH);
    end
    wr(9'h0F8, 8'h15);
    checks++;
    if ({bus.level, bus.notify} !== {7'd6, 1'b1}) begin
      errors++; $display("FAIL notify_hold: got %h want %h", {bus.level, bus.notify}, {7'd6, 1'b1});
    end
    for (int i = 0; i < 6; i++) begin
      pop(d, v);
      checks++;
      if ({v, d} !== {1'b1, 8'h10 + 8'(i)}) begin
        errors++; $display("FAIL flush_pop[%0d]: got %h want %h", i, {v, d}, {1'b1, 8'h10 + 8'(i)});
      end
    end
    checks++;
    if ({bus.level, bus.notify} !== {7'd0, 1'b0}) begin
      errors++; $display("FAIL notify_release: got %h want %h", {bus.level, bus.notify}, {7'd0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d; logic v;
    push_pop(8'h55, d, v);
    checks++;
    if ({v, d, bus.level} !== {1'b0, 8'h00, 7'd1}) begin
      errors++; $display("FAIL pushpop_empty: got %h want %h", {v, d, bus.level}, {1'b0, 8'h00, 7'd1});
    end
    push_pop(8'h66, d, v);
    checks++;
    if ({v, d, bus.level} !== {1'b1, 8'h55, 7'd1}) begin
      errors++; $display("FAIL pushpop_mid: got %h want %h", {v, d, bus.level}, {1'b1, 8'h55, 7'd1});
    end
    pop(d, v);
    checks++;
    if ({v, d, bus.level} !== {1'b1, 8'h66, 7'd0}) begin
      errors++; $display("FAIL pushpop_mid_pop: got %h want %h", {v, d, bus.level}, {1'b1, 8'h66, 7'd0});
    end
    for (int i = 0; i < 64; i++) wr(9'h0F9, 8'h80 + 8'(i));
    push_pop(8'hEE, d, v);
    checks++;
    if ({v, d} !== {1'b1, 8'h80} || snap() !== {8'hB0, 7'd64, 3'b101, 8'h80}) begin
      errors++; $display("FAIL pushpop_full: got %h want %h", snap(), {8'hB0, 7'd64, 3'b101, 8'h80});
    end
    for (int i = 1; i < 65; i++) begin
      pop(d, v);
      checks++;
      if ({v, d} !== {1'b1, (i == 64) ? 8'hEE : 8'h80 + 8'(i)}) begin
        errors++; $display("FAIL full_pop[%0d]: got %h want %h", i, {v, d}, {1'b1, (i == 64) ? 8'hEE : 8'h80 + 8'(i)});
      end
    end
    pop(d, v);
    checks++;
    if ({v, bus.level, bus.notify} !== {1'b0, 7'd0, 1'b0}) begin
      errors++; $display("FAIL full_drain_end: got %h want %h", {v, bus.level, bus.notify}, {1'b0, 7'd0, 1'b0});
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic v;
    for (int i = 0; i < 21; i++) wr(9'h0F8, 8'h40 + 8'(i));
    pop(d, v);
    checks++;
    if (snap() !== {8'h30, 7'd20, 3'b001, 8'h40}) begin
      errors++; $display("FAIL pre_reset: got %h want %h", snap(), {8'h30, 7'd20, 3'b001, 8'h40});
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (snap() !== {8'h30, 7'd0, 3'b000, 8'h00}) begin
      errors++; $display("FAIL async_reset: got %h want %h", snap(), {8'h30, 7'd0, 3'b000, 8'h00});
    end
    tick();
    rst_n = 1'b1;
    tick();
    pop(d, v);
    checks++;
    if ({v, d, bus.level} !== {1'b0, 8'h00, 7'd0}) begin
      errors++; $display("FAIL post_reset_pop: got %h want %h", {v, d, bus.level}, {1'b0, 8'h00, 7'd0});
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_abc();
    test_fill_overflow();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
